// File: rtl/fifo_pkg.sv
// fifo_pkg: shared width helpers for the parametrised FIFO
package fifo_pkg;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int addr_w(input int depth);
    return depth > 1 ? clog2(depth) : 1;
  endfunction
  function automatic int cnt_w(input int depth);
    return clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fifo_param_mem.sv
// fifo_param_mem: WIDTH x DEPTH array, sync write port, registered read port
module fifo_param_mem import fifo_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW = addr_w(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [AW-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic re,
  input  logic [AW-1:0] raddr,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk)
    if (rst) dout <= '0;
    else if (re) dout <= mem[raddr];
endmodule

// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO with occupancy count and sticky error flags
module fifo_param import fifo_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int PE_LEVEL = 4,
  parameter int PF_LEVEL = 12
) (
  input  logic clk,
  input  logic RESET,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic WE,
  input  logic RE,
  output logic [WIDTH-1:0] DOUT,
  output logic EF,
  output logic PEF,
  output logic FF,
  output logic PFF,
  output logic [clog2(DEPTH+1)-1:0] COUNT,
  output logic OVF,
  output logic UDF
);
  localparam int AW = addr_w(DEPTH);
  localparam int CW = clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] PE_C = CW'(PE_LEVEL);
  localparam logic [CW-1:0] PF_C = CW'(PF_LEVEL);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  logic [AW-1:0] wptr, rptr;
  logic wr_ok, rd_ok;
  // a full FIFO still takes a write when a read frees the slot in the same edge
  assign wr_ok = !RESET && WE && (!FF || RE);
  assign rd_ok = !RESET && RE && !EF;
  assign EF = COUNT == '0;
  assign PEF = !EF && COUNT <= PE_C;
  assign FF = COUNT == FULL_C;
  assign PFF = COUNT >= PF_C && !FF;
  always_ff @(posedge clk)
    if (RESET) begin
      wptr <= '0;
      rptr <= '0;
      COUNT <= '0;
      OVF <= 1'b0;
      UDF <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr == LAST ? '0 : wptr + 1'b1;
      if (rd_ok) rptr <= rptr == LAST ? '0 : rptr + 1'b1;
      COUNT <= COUNT + CW'(wr_ok) - CW'(rd_ok);
      if (WE && FF && !RE) OVF <= 1'b1;
      if (RE && EF) UDF <= 1'b1;
    end
  fifo_param_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk(clk),
    .rst(RESET),
    .we(wr_ok),
    .waddr(wptr),
    .wdata(DATA_IN),
    .re(rd_ok),
    .raddr(rptr),
    .dout(DOUT)
  );
endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: scoreboard bench for a 16-deep and a 12-deep fifo_param fed identical stimulus
module tb_fifo_param;
  logic clk = 0, rst = 1, we = 0, re = 0;
  logic [7:0] din = 0;
  logic [7:0] d16, d12;
  logic [4:0] c16;
  logic [3:0] c12;
  logic ef16, pef16, ff16, pff16, ovf16, udf16;
  logic ef12, pef12, ff12, pff12, ovf12, udf12;
  int checks = 0, errors = 0;
  logic [7:0] q16[$], sb16[$], q12[$], sb12[$];
  logic [7:0] e16 = 0, e12 = 0, lfsr = 8'h01;
  logic m_ovf16 = 0, m_udf16 = 0, m_ovf12 = 0, m_udf12 = 0;

  always #5 clk = ~clk;

  fifo_param u16 (.clk(clk), .RESET(rst), .DATA_IN(din), .WE(we), .RE(re), .DOUT(d16),
    .EF(ef16), .PEF(pef16), .FF(ff16), .PFF(pff16), .COUNT(c16), .OVF(ovf16), .UDF(udf16));
  fifo_param #(.DEPTH(12), .PE_LEVEL(3), .PF_LEVEL(9)) u12 (.clk(clk), .RESET(rst), .DATA_IN(din),
    .WE(we), .RE(re), .DOUT(d12), .EF(ef12), .PEF(pef12), .FF(ff12), .PFF(pff12), .COUNT(c12),
    .OVF(ovf12), .UDF(udf12));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_flags(input int n, input int d, input int pe, input int pf);
    return {n == 0, n > 0 && n <= pe, n == d, n >= pf && n < d};
  endfunction

  // reference models: plain queues following the accept rules; reads push the expected DOUT
  always @(posedge clk) begin
    int n;
    if (rst) begin
      q16.delete(); sb16.delete(); sb16.push_back(8'h00); m_ovf16 = 0; m_udf16 = 0;
    end else begin
      n = q16.size();
      if (we && n == 16 && !re) m_ovf16 = 1;
      if (re && n == 0) m_udf16 = 1;
      if (re && n > 0) sb16.push_back(q16.pop_front());
      if (we && (n < 16 || re)) q16.push_back(din);
    end
  end

  always @(posedge clk) begin
    int n;
    if (rst) begin
      q12.delete(); sb12.delete(); sb12.push_back(8'h00); m_ovf12 = 0; m_udf12 = 0;
    end else begin
      n = q12.size();
      if (we && n == 12 && !re) m_ovf12 = 1;
      if (re && n == 0) m_udf12 = 1;
      if (re && n > 0) sb12.push_back(q12.pop_front());
      if (we && (n < 12 || re)) q12.push_back(din);
    end
  end

  always @(negedge clk) begin
    if (sb16.size() > 0) e16 = sb16.pop_front();
    if (sb12.size() > 0) e12 = sb12.pop_front();
    chk("dout16", d16, e16);
    chk("count16", c16, q16.size());
    chk("flags16", {ef16, pef16, ff16, pff16}, exp_flags(q16.size(), 16, 4, 12));
    chk("err16", {ovf16, udf16}, {m_ovf16, m_udf16});
    chk("dout12", d12, e12);
    chk("count12", c12, q12.size());
    chk("flags12", {ef12, pef12, ff12, pff12}, exp_flags(q12.size(), 12, 3, 9));
    chk("err12", {ovf12, udf12}, {m_ovf12, m_udf12});
    chk("ptr12", u12.wptr < 12 && u12.rptr < 12, 1);
  end

  task automatic drive(input logic r, input logic w, input logic rd, input logic [7:0] d);
    rst = r; we = w; re = rd; din = d;
    @(negedge clk);
  endtask

  initial begin
    int n, p;
    logic w, r;
    @(negedge clk);
    drive(1, 0, 0, 0);
    for (int i = 1; i <= 16; i++) drive(0, 1, 0, 8'(i));
    drive(0, 1, 0, 8'd99);
    chk("fill_count", c16, 16);
    chk("fill_ovf", ovf16, 1);
    for (int i = 0; i < 16; i++) drive(0, 0, 1, 0);
    chk("drain_ef", ef16, 1);
    drive(0, 0, 1, 0);
    chk("drain_udf", udf16, 1);
    chk("drain_dout", d16, 16);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 8'(8'h10 + i));
    for (int i = 0; i < 10; i++) drive(0, 1, 1, 8'(8'h20 + i));
    chk("simul_count", c16, 5);
    for (int i = 0; i < 11; i++) drive(0, 1, 0, 8'(8'h40 + i));
    drive(0, 1, 1, 8'h55);
    chk("full_both_count", c16, 16);
    chk("full_both_ovf", ovf16, 0);
    for (int i = 0; i < 16; i++) drive(0, 0, 1, 0);
    drive(0, 1, 1, 8'h66);
    chk("empty_both_count", c16, 1);
    chk("empty_both_udf", udf16, 1);
    chk("empty_both_dout", d16, 8'h55);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      n = q12.size();
      w = n < 12 ? 1'($urandom % 2) : 1'b0;
      r = n > 0 ? 1'($urandom % 2) : 1'b0;
      if (!w && !r) begin
        w = n < 12;
        r = !w;
      end
      drive(0, w, r, 8'($urandom));
    end
    drive(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) drive(0, 1, 0, 8'(8'h70 + i));
    drive(1, 1, 1, 8'h77);
    drive(0, 0, 0, 0);
    chk("rst_count", c16, 0);
    chk("rst_ef", ef16, 1);
    chk("rst_dout", d16, 0);
    chk("rst_err", {ovf16, udf16}, 0);
    drive(0, 1, 0, 8'hA5);
    drive(0, 0, 1, 0);
    chk("rst_new_data", d16, 8'hA5);
    for (int i = 0; i < 5000; i++) begin
      p = (i / 500) % 2 ? 30 : 70;
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      drive(0, $urandom_range(99) < p, $urandom_range(99) < 100 - p, lfsr);
    end
    drive(0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO, the successor to the fixed 8-bit/16-deep FIFO. Width, depth and both partial-flag thresholds are configurable, and depth need not be a power of two. It adds an occupancy count and sticky overflow/underflow error flags. It sits between a data producer (e.g. an LFSR source) and a consumer on a single clock domain, with the same flag set as the existing FIFO.

## Interface
Parameters:
- WIDTH, 8: data width in bits, ≥1.
- DEPTH, 16: number of entries, ≥2, any integer.
- PE_LEVEL, 4: partially-empty threshold, 1 ≤ PE_LEVEL < DEPTH.
- PF_LEVEL, 12: partially-full threshold, PE_LEVEL < PF_LEVEL < DEPTH.

Ports:
- clk  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- DATA_IN  in  WIDTH  write data.
- WE  in  1  write request.
- RE  in  1  read request.
- DOUT  out  WIDTH  registered read data.
- EF  out  1  empty: count == 0.
- PEF  out  1  partially empty: 0 < count ≤ PE_LEVEL.
- FF  out  1  full: count == DEPTH.
- PFF  out  1  partially full: PF_LEVEL ≤ count < DEPTH.
- COUNT  out  clog2(DEPTH+1)  current occupancy.
- OVF  out  1  sticky: a write was attempted while full.
- UDF  out  1  sticky: a read was attempted while empty.

## Operation
- A write is accepted when WE=1 and the FIFO is not full, or when WE=1, RE=1 and the FIFO is full. DATA_IN is stored at wptr, and wptr advances.
- A read is accepted when RE=1 and count > 0. mem[rptr] is loaded into DOUT, and rptr advances.
- Pointers run from 0 to DEPTH-1 and wrap to 0 explicitly after DEPTH-1. No reliance on binary rollover.
- COUNT changes as follows:
  - +1 on write only.
  - −1 on read only.
  - Unchanged on a simultaneous accepted read and write, or when nothing is accepted.
- Empty with WE=1 and RE=1: only the write is accepted. There is no read-through, DOUT is unchanged and UDF is set.
- Full with WE=1 and RE=1: both are accepted, COUNT stays DEPTH, and OVF is not set.
- OVF sets when WE=1, count == DEPTH and RE=0.
- UDF sets when RE=1 and count == 0.
- OVF and UDF clear only on RESET.
- Rejected operations change no pointer, no memory entry and no DOUT.
- DOUT holds its last value when no read is accepted.
- The flags EF, PEF, FF and PFF are combinational decodes of the COUNT register. They are mutually consistent: EF and PEF are exclusive, FF and PFF are exclusive, and EF and FF are exclusive.
- Memory contents are not reset.

## Timing
- Reset values:
  - DOUT = 0, COUNT = 0.
  - EF = 1; PEF = 0, FF = 0, PFF = 0.
  - OVF = 0, UDF = 0.
  - wptr = 0, rptr = 0.
- RESET has priority over WE and RE in the same cycle. Any in-flight operation is discarded.
- Read latency: DOUT is valid 1 cycle after the edge that accepts RE.
- Write-to-read latency: data written at edge n is readable by a read accepted at edge n+1. EF deasserts after edge n.
- Flags and COUNT reflect the state after the last edge, with no additional register stage.

## Structure
- Shared package fifo_pkg:
  - a clog2 function;
  - address width derived from DEPTH;
  - count width derived from DEPTH+1.
- Sub-module fifo_param_mem: a WIDTH×DEPTH register array with one synchronous write port and one synchronous registered read port (DOUT register included, reset to 0).
- The top level holds the pointers, COUNT, flag decode and sticky errors.
- Target size is about 150–250 lines of RTL.

## Test plan
Scenarios use WIDTH=8, DEPTH=16, PE_LEVEL=4, PF_LEVEL=12 unless stated otherwise.
- Fill: RESET, then write 1..16 with RE=0.
  - COUNT steps 1..16.
  - PEF is set at counts 1–4.
  - PFF is set at counts 12–15.
  - FF=1 at 16; EF=0 throughout.
  - A 17th write sets OVF=1 and leaves COUNT=16.
- Drain: from full, read 16 times.
  - DOUT = 1..16 in order, each one cycle after its RE.
  - EF=1 after the 16th read.
  - A 17th RE sets UDF=1; DOUT stays 16.
- Simultaneous access:
  - At count 5, WE+RE for 10 cycles: COUNT stays 5 and data order is preserved.
  - When full, WE+RE: accepted, COUNT=16, OVF stays 0.
  - When empty, WE+RE: COUNT becomes 1, DOUT unchanged, UDF=1.
- Non-power-of-two wrap with DEPTH=12, PE_LEVEL=3, PF_LEVEL=9:
  - Perform 40 writes and reads interleaved, keeping count between 0 and 12.
  - DOUT matches a reference queue throughout.
  - Pointers never exceed 11.
- Reset mid-operation: assert RESET for 1 cycle at count 7 with WE=RE=1.
  - Next cycle: COUNT=0, EF=1, DOUT=0, OVF=0, UDF=0.
  - A subsequent write then read returns the new data, not stale entries.
- Random soak: 5000 cycles of random WE/RE and LFSR-driven DATA_IN.
  - All outputs are checked every cycle against a behavioral queue model.
